mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, flags misaligned and
// timed-out accesses, resolves the branch redirect and loads the MEM/WB register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [63:0] pc_in,
    input  logic        zero_in,
    input  logic        branch_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] read_data2_in,
    input  logic [4:0]  write_reg_in,
    input  logic        memwrite_in,
    input  logic        memread_in,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pcsrc,
    output logic [63:0] branch_target,
    output logic        wb_valid,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_reg,
    output logic        wb_memtoreg,
    output logic        wb_regwrite,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_wait_cnt;

    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic          r_rd;
    logic [4:0]    r_wreg;
    logic          r_memtoreg;
    logic          r_regwrite;

    logic          r_wb_valid;
    logic [31:0]   r_wb_read_data;
    logic [31:0]   r_wb_alu_result;
    logic [4:0]    r_wb_write_reg;
    logic          r_wb_memtoreg;
    logic          r_wb_regwrite;
    logic          r_misalign_err;
    logic          r_timeout_err;

    logic          w_in_wait;
    logic          w_memop;
    logic          w_aligned;
    logic          w_issue;
    logic          w_misalign;
    logic          w_timeout;

    assign w_in_wait  = (r_state == S_WAIT);
    assign w_memop    = memread_in | memwrite_in;
    assign w_aligned  = (alu_result_in[1:0] == 2'b00);
    assign w_issue    = !w_in_wait && valid_in && w_memop && w_aligned;
    assign w_misalign = !w_in_wait && valid_in && w_memop && !w_aligned;
    // The abort cycle withdraws the request, so a stall run is at most TIMEOUT+1 cycles.
    assign w_timeout  = w_in_wait && (r_wait_cnt == CW'(TIMEOUT));

    always_comb begin
        stall    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pcsrc    = 1'b0;
        if (!rst) begin
            if (w_in_wait) begin
                if (!w_timeout) begin
                    dmem_req = 1'b1;
                    dmem_we  = r_we;
                    stall    = !dmem_ready;
                end
            end else begin
                stall = w_issue;
                pcsrc = valid_in & branch_in & zero_in;
            end
        end
    end

    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign branch_target = pc_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_we            <= 1'b0;
            r_rd            <= 1'b0;
            r_wreg          <= '0;
            r_memtoreg      <= 1'b0;
            r_regwrite      <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_read_data  <= '0;
            r_wb_alu_result <= '0;
            r_wb_write_reg  <= '0;
            r_wb_memtoreg   <= 1'b0;
            r_wb_regwrite   <= 1'b0;
            r_misalign_err  <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else if (!w_in_wait) begin
            if (w_issue) begin
                r_state    <= S_WAIT;
                r_wait_cnt <= '0;
                r_addr     <= alu_result_in;
                r_wdata    <= read_data2_in;
                r_we       <= memwrite_in;
                r_rd       <= memread_in;
                r_wreg     <= write_reg_in;
                r_memtoreg <= memtoreg_in;
                r_regwrite <= regwrite_in & ~memwrite_in;
            end else if (!valid_in || w_misalign) begin
                // Bubble: only the qualifying bits drop, data fields keep their values.
                r_wb_valid    <= 1'b0;
                r_wb_regwrite <= 1'b0;
                r_wb_memtoreg <= 1'b0;
                if (w_misalign) begin
                    r_misalign_err <= 1'b1;
                end
            end else begin
                r_wb_valid      <= 1'b1;
                r_wb_read_data  <= '0;
                r_wb_alu_result <= alu_result_in;
                r_wb_write_reg  <= write_reg_in;
                r_wb_memtoreg   <= memtoreg_in;
                r_wb_regwrite   <= regwrite_in;
            end
        end else begin
            if (w_timeout) begin
                r_state       <= S_IDLE;
                r_timeout_err <= 1'b1;
                r_wb_valid    <= 1'b0;
                r_wb_regwrite <= 1'b0;
                r_wb_memtoreg <= 1'b0;
            end else if (dmem_ready) begin
                r_state         <= S_IDLE;
                r_wb_valid      <= 1'b1;
                r_wb_read_data  <= r_rd ? dmem_rdata : '0;
                r_wb_alu_result <= r_addr;
                r_wb_write_reg  <= r_wreg;
                r_wb_memtoreg   <= r_memtoreg;
                r_wb_regwrite   <= r_regwrite;
            end else begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end
    end

    assign wb_valid      = r_wb_valid;
    assign wb_read_data  = r_wb_read_data;
    assign wb_alu_result = r_wb_alu_result;
    assign wb_write_reg  = r_wb_write_reg;
    assign wb_memtoreg   = r_wb_memtoreg;
    assign wb_regwrite   = r_wb_regwrite;
    assign misalign_err  = r_misalign_err;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes the expected MEM/WB image per
// issued slot; the monitor pops it on every non-stalled edge and checks holds otherwise.
module tb_mem_stage;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [63:0] pc_in;
    logic        zero_in;
    logic        branch_in;
    logic [31:0] alu_result_in;
    logic [31:0] read_data2_in;
    logic [4:0]  write_reg_in;
    logic        memwrite_in;
    logic        memread_in;
    logic        memtoreg_in;
    logic        regwrite_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        pcsrc;
    logic [63:0] branch_target;
    logic        wb_valid;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_write_reg;
    logic        wb_memtoreg;
    logic        wb_regwrite;
    logic        misalign_err;
    logic        timeout_err;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .pc_in         (pc_in),
        .zero_in       (zero_in),
        .branch_in     (branch_in),
        .alu_result_in (alu_result_in),
        .read_data2_in (read_data2_in),
        .write_reg_in  (write_reg_in),
        .memwrite_in   (memwrite_in),
        .memread_in    (memread_in),
        .memtoreg_in   (memtoreg_in),
        .regwrite_in   (regwrite_in),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .stall         (stall),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .wb_valid      (wb_valid),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_write_reg  (wb_write_reg),
        .wb_memtoreg   (wb_memtoreg),
        .wb_regwrite   (wb_regwrite),
        .misalign_err  (misalign_err),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        mtr;
        logic        rw;
    } wb_t;

    wb_t         q[$];
    wb_t         mon_last;
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] m_rd  = '0;
    logic [31:0] m_alu = '0;
    logic [4:0]  m_wr  = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic wb_cmp(input string tag, input wb_t e);
        chk({tag, "_valid"},    wb_valid,      e.v);
        chk({tag, "_rdata"},    wb_read_data,  e.rd);
        chk({tag, "_alu"},      wb_alu_result, e.alu);
        chk({tag, "_wreg"},     wb_write_reg,  e.wr);
        chk({tag, "_memtoreg"}, wb_memtoreg,   e.mtr);
        chk({tag, "_regwrite"}, wb_regwrite,   e.rw);
    endtask

    // Monitor: reset edges clear, non-stalled edges pop, stalled edges must hold.
    initial begin
        logic cap_w;
        logic cap_r;
        wb_t  e;
        mon_last = '{1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            cap_r = rst;
            cap_w = !rst && !stall;
            @(posedge clk);
            #1;
            if (cap_r) begin
                mon_last = '{1'b0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0};
                wb_cmp("rst_wb", mon_last);
            end else if (cap_w) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    wb_cmp("wb", e);
                    mon_last = e;
                end
            end else begin
                wb_cmp("hold", mon_last);
            end
        end
    end

    // Drives one EX/MEM slot at posedge+1 and plays the memory side; returns at posedge+1.
    task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input logic mr, input logic mw,
                         input logic mtr, input logic rw, input logic br, input logic z,
                         input int unsigned lat, input logic [31:0] rdata);
        wb_t         e;
        logic        memop;
        logic        aligned;
        logic        goes_wait;
        int unsigned nst;
        int unsigned exp_st;
        nst       = 0;
        memop     = mr | mw;
        aligned   = (alu[1:0] == 2'b00);
        goes_wait = v && memop && aligned;
        exp_st    = goes_wait ? 1 + ((lat < TMO) ? lat : TMO) : 0;

        valid_in      = v;
        alu_result_in = alu;
        read_data2_in = wd;
        write_reg_in  = wr;
        memread_in    = mr;
        memwrite_in   = mw;
        memtoreg_in   = mtr;
        regwrite_in   = rw;
        branch_in     = br;
        zero_in       = z;
        pc_in         = {32'hC000_0000 ^ wd, alu + 32'h10};
        dmem_ready    = 1'b0;

        if (!v || (memop && !aligned) || (goes_wait && lat >= TMO))
            e = '{1'b0, m_rd, m_alu, m_wr, 1'b0, 1'b0};
        else if (!memop)
            e = '{1'b1, 32'h0, alu, wr, mtr, rw};
        else
            e = '{1'b1, mr ? rdata : 32'h0, alu, wr, mtr, rw & ~mw};
        q.push_back(e);
        m_rd  = e.rd;
        m_alu = e.alu;
        m_wr  = e.wr;

        @(negedge clk);
        chk("pcsrc_idle", pcsrc, v & br & z);
        chk("btarget", branch_target, {32'hC000_0000 ^ wd, alu + 32'h10});
        chk("req_idle", dmem_req, 1'b0);
        chk("we_idle", dmem_we, 1'b0);
        chk("stall_idle", stall, goes_wait);
        if (stall) nst++;
        @(posedge clk);
        #1;
        if (goes_wait) begin
            for (int unsigned k = 0; k <= TMO; k++) begin
                dmem_ready = (k == lat);
                dmem_rdata = (k == lat) ? rdata : $urandom;
                @(negedge clk);
                if (k == TMO) begin
                    chk("req_abort", dmem_req, 1'b0);
                    chk("stall_abort", stall, 1'b0);
                end else begin
                    chk("req_wait", dmem_req, 1'b1);
                    chk("addr_wait", dmem_addr, alu);
                    chk("we_wait", dmem_we, mw);
                    chk("wdata_wait", dmem_wdata, wd);
                    chk("stall_wait", stall, !dmem_ready);
                end
                chk("pcsrc_wait", pcsrc, 1'b0);
                if (stall) nst++;
                @(posedge clk);
                #1;
                if (k == lat || k == TMO) break;
            end
            dmem_ready = 1'b0;
        end
        chk("stall_cycles", nst, exp_st);
    endtask

    initial begin
        logic [31:0] a;
        int unsigned kind;
        rst = 1'b1;
        valid_in = 1'b0; pc_in = '0; zero_in = 1'b0; branch_in = 1'b0;
        alu_result_in = '0; read_data2_in = '0; write_reg_in = '0;
        memwrite_in = 1'b0; memread_in = 1'b0; memtoreg_in = 1'b0; regwrite_in = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        @(negedge clk);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_misalign", misalign_err, 1'b0);
        chk("rst_timeout", timeout_err, 1'b0);

        issue(1, 32'h1234, 32'h0, 5'd5, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        issue(0, 32'hFFFF_FFF0, 32'h7, 5'd9, 0, 0, 1, 1, 1, 1, 0, 32'h0);
        issue(1, 32'h100, 32'h0, 5'd7, 1, 0, 1, 1, 1, 1, 3, 32'hDEAD_BEEF);
        issue(1, 32'h40, 32'h55, 5'd3, 0, 1, 0, 1, 0, 0, 0, 32'h0);
        issue(1, 32'h102, 32'h0, 5'd8, 1, 0, 1, 1, 1, 0, 0, 32'h1111_2222);
        chk("misalign_set", misalign_err, 1'b1);
        issue(1, 32'h2468, 32'h0, 5'd12, 0, 0, 0, 1, 1, 1, 0, 32'h0);
        chk("misalign_sticky", misalign_err, 1'b1);
        chk("timeout_clear", timeout_err, 1'b0);
        issue(1, 32'h200, 32'h0, 5'd14, 1, 0, 1, 1, 0, 0, 255, 32'h0);
        chk("timeout_set", timeout_err, 1'b1);
        issue(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("timeout_sticky", timeout_err, 1'b1);

        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            a[1:0] = 2'b00;
            issue(1, a, $urandom, 5'($urandom), kind == 1, kind == 2, kind == 1, 1,
                  1'($urandom), 1'($urandom), $urandom_range(0, TMO - 1), $urandom);
        end

        // Abandon a load in flight with reset.
        valid_in = 1'b1; alu_result_in = 32'h300; memread_in = 1'b1; memwrite_in = 1'b0;
        branch_in = 1'b1; zero_in = 1'b1; dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_req", dmem_req, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstcyc_req", dmem_req, 1'b0);
        chk("rstcyc_stall", stall, 1'b0);
        chk("rstcyc_pcsrc", pcsrc, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_rd = '0; m_alu = '0; m_wr = '0;
        chk("post_rst_valid", wb_valid, 1'b0);
        chk("post_rst_misalign", misalign_err, 1'b0);
        chk("post_rst_timeout", timeout_err, 1'b0);
        issue(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        issue(1, 32'h44, 32'h99, 5'd2, 1, 0, 1, 1, 0, 0, 1, 32'hCAFE_F00D);

        @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
